// File: rtl/instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue
//   Instruction prefetch queue sitting between an instruction memory port and
//   the ID stage. A three-state fetch FSM (IDLE/WAIT/DRAIN) keeps at most one
//   memory read outstanding. Responses go into a DEPTH-entry FIFO that holds
//   {instruction word, fetch address + 1}. A flush (taken-branch redirect)
//   empties the FIFO, reloads the fetch PC and discards any in-flight response.
//
//   Optional feature, enabled by defining PFQ_HLT_DETECT_EN: once a word whose
//   opcode field [31:26] is all ones has been pushed, no further fetches are
//   issued until the next flush or rst.
// -----------------------------------------------------------------------------
module instr_prefetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic                   clk1,
    input  logic                   rst,
    input  logic                   halt,
    input  logic                   flush,
    input  logic [31:0]            flush_pc,
    output logic                   mem_req,
    output logic [AW-1:0]          mem_addr,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_ir,
    output logic [31:0]            out_npc,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int              PW      = $clog2(DEPTH);
    localparam logic [PW:0]     LP_FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t          r_state;
    logic [31:0]     r_fetch_pc;
    logic            r_mem_req;
    logic [AW-1:0]   r_mem_addr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW:0]     r_count;
    logic [31:0]     r_ir_mem  [DEPTH];
    logic [31:0]     r_npc_mem [DEPTH];

    logic            w_push;
    logic            w_pop;
    logic            w_issue;
    logic            w_hlt_block;

    // A response is kept only if it completes a live request (not in DRAIN)
    // and no redirect arrives in the same cycle.
    assign w_push  = !rst && (r_state == ST_WAIT) && mem_ack && !flush;
    // A flush overrides a same-cycle pop.
    assign w_pop   = !rst && (r_count != '0) && out_ready && !flush;
    // Issue is gated on the queue's current occupancy, so the single
    // outstanding response always has a free slot when it arrives.
    assign w_issue = (r_state == ST_IDLE) && !halt && !flush &&
                     (r_count < LP_FULL) && !w_hlt_block;

`ifdef PFQ_HLT_DETECT_EN
    logic r_hlt_stop;

    // Latch a "halt instruction seen" flag that stops issue until redirect.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_hlt_stop <= 1'b0;
        end else if (flush) begin
            r_hlt_stop <= 1'b0;
        end else if (w_push && (mem_rdata[31:26] == 6'b111111)) begin
            r_hlt_stop <= 1'b1;
        end
    end

    assign w_hlt_block = r_hlt_stop;
`else
    assign w_hlt_block = 1'b0;
`endif

    // Fetch FSM: issues one read at a time and tracks the fetch PC.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (flush) begin
                        r_fetch_pc <= flush_pc;
                    end else if (w_issue) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_fetch_pc[AW-1:0];
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        // Request done either way; a coincident flush just
                        // discards the word and redirects.
                        r_mem_req  <= 1'b0;
                        r_state    <= ST_IDLE;
                        r_fetch_pc <= flush ? flush_pc : r_fetch_pc + 32'd1;
                    end else if (flush) begin
                        // The memory still owes us a response; wait it out.
                        r_fetch_pc <= flush_pc;
                        r_state    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (flush) begin
                        r_fetch_pc <= flush_pc;
                    end
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy counter; flush empties the queue.
    always_ff @(posedge clk1) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: instruction word and its next-PC.
    // NOTE: the storage array has no reset; validity comes solely from the
    // occupancy counter, and the outputs are forced to zero when it is empty.
    always_ff @(posedge clk1) begin
        if (w_push) begin
            r_ir_mem[r_wr_ptr]  <= mem_rdata;
            r_npc_mem[r_wr_ptr] <= r_fetch_pc + 32'd1;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign occupancy = r_count;
    assign out_valid = (r_count != '0);
    assign out_ir    = out_valid ? r_ir_mem[r_rd_ptr]  : 32'd0;
    assign out_npc   = out_valid ? r_npc_mem[r_rd_ptr] : 32'd0;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch_queue
//   Self-checking bench for instr_prefetch_queue. A memory responder returns
//   word(addr) = addr + 100 after a programmable latency. The reference model
//   tracks program order: the expected next fetch address, the expected next
//   popped address, the number of buffered words, and whether the outstanding
//   request was overtaken by a redirect. Build with +define+PFQ_HLT_DETECT_EN
//   to exercise the optional halt-instruction detection.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_prefetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 10;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          clk1 = 1'b0;
    logic          rst;
    logic          halt;
    logic          flush;
    logic [31:0]   flush_pc;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_ir;
    logic [31:0]   out_npc;
    logic [OW-1:0] occupancy;

    instr_prefetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .halt      (halt),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ir    (out_ir),
        .out_npc   (out_npc),
        .occupancy (occupancy)
    );

    always #5 clk1 = ~clk1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_count;
    logic [31:0]   exp_fetch;
    logic [31:0]   exp_pop;
    bit            tainted;
    bit            m_hlt;

    // Previous-cycle observations
    bit            p_req, p_ack, p_halt, p_flush, p_rst, p_hlt;
    int            p_count;
    logic [AW-1:0] p_addr;

    // Memory responder controls
    int            wait_cnt;
    int            cur_lat;
    bit            rand_lat;
    bit            auto_ack;
    bit            manual_ack;
    bit            hlt_word_en;

    // Logs of issued request addresses and popped entries
    logic [AW-1:0] req_log[$];
    logic [31:0]   pop_ir[$];
    logic [31:0]   pop_npc[$];

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        if (hlt_word_en && a == AW'(5)) return 32'hFC00_0000;
        return 32'(a) + 32'd100;
    endfunction

    task automatic model_reset();
        m_count   = 0;
        exp_fetch = 32'd0;
        exp_pop   = 32'd0;
        tainted   = 1'b0;
        m_hlt     = 1'b0;
        wait_cnt  = 0;
    endtask

    task automatic clear_logs();
        req_log.delete();
        pop_ir.delete();
        pop_npc.delete();
    endtask

    // Compare DUT against the model for the current cycle, then apply the
    // events that the coming clock edge will commit.
    task automatic monitor();
        logic [31:0] w;
        checks++;
        if (occupancy !== OW'(m_count)) begin
            errors++;
            $display("FAIL occupancy: got %0d expected %0d at %0t", occupancy, m_count, $time);
        end
        checks++;
        if (out_valid !== (m_count != 0)) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b at %0t", out_valid, (m_count != 0), $time);
        end
        if (m_count == 0) begin
            checks++;
            if (out_ir !== 32'd0 || out_npc !== 32'd0) begin
                errors++;
                $display("FAIL empty_outputs: got ir=%h npc=%h expected 0/0 at %0t", out_ir, out_npc, $time);
            end
        end

        if (p_rst) begin
            checks++;
            if (mem_req !== 1'b0 || mem_addr !== '0) begin
                errors++;
                $display("FAIL reset_req: got req=%b addr=%h expected 0/0 at %0t", mem_req, mem_addr, $time);
            end
        end else if (p_req && p_ack) begin
            checks++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL issue_spacing: got req=%b expected 0 after ack at %0t", mem_req, $time);
            end
        end else if (p_req) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== p_addr) begin
                errors++;
                $display("FAIL req_hold: got req=%b addr=%h expected 1/%h at %0t", mem_req, mem_addr, p_addr, $time);
            end
        end else if (mem_req === 1'b1) begin
            req_log.push_back(mem_addr);
            checks++;
            if (mem_addr !== exp_fetch[AW-1:0]) begin
                errors++;
                $display("FAIL req_addr: got %h expected %h at %0t", mem_addr, exp_fetch[AW-1:0], $time);
            end
            checks++;
            if (p_halt || p_flush || p_count >= DEPTH || p_hlt) begin
                errors++;
                $display("FAIL issue_gate: got issue with halt=%b flush=%b occ=%0d hlt=%b expected no issue at %0t",
                         p_halt, p_flush, p_count, p_hlt, $time);
            end
        end

        if (mem_req === 1'b1 && mem_ack !== 1'b1) wait_cnt++;
        else wait_cnt = 0;
        if (mem_req === 1'b1 && mem_ack === 1'b1) cur_lat = rand_lat ? int'($urandom_range(0, 3)) : 1;

        p_req   = (mem_req === 1'b1);
        p_ack   = (mem_ack === 1'b1);
        p_addr  = mem_addr;
        p_halt  = halt;
        p_flush = flush;
        p_rst   = rst;
        p_count = m_count;
        p_hlt   = m_hlt;

        if (rst) begin
            model_reset();
        end else if (flush) begin
            tainted   = (mem_req === 1'b1 && mem_ack !== 1'b1);
            m_count   = 0;
            exp_fetch = flush_pc;
            exp_pop   = flush_pc;
            m_hlt     = 1'b0;
        end else begin
            if (m_count != 0 && out_ready) begin
                checks++;
                if (out_ir !== mem_word(exp_pop[AW-1:0]) || out_npc !== exp_pop + 32'd1) begin
                    errors++;
                    $display("FAIL pop_data: got ir=%h npc=%h expected ir=%h npc=%h at %0t",
                             out_ir, out_npc, mem_word(exp_pop[AW-1:0]), exp_pop + 32'd1, $time);
                end
                pop_ir.push_back(out_ir);
                pop_npc.push_back(out_npc);
                exp_pop = exp_pop + 32'd1;
                m_count--;
            end
            if (mem_req === 1'b1 && mem_ack === 1'b1) begin
                if (!tainted) begin
                    w = mem_word(mem_addr);
`ifdef PFQ_HLT_DETECT_EN
                    if (w[31:26] == 6'b111111) m_hlt = 1'b1;
`endif
                    m_count++;
                    exp_fetch = exp_fetch + 32'd1;
                end
                tainted = 1'b0;
            end
        end
    endtask

    // One clock cycle: memory responds, outputs are checked mid-cycle, and
    // control returns just after the next rising edge.
    task automatic step();
        mem_ack   = auto_ack ? (mem_req === 1'b1 && wait_cnt >= cur_lat) : manual_ack;
        mem_rdata = mem_word(mem_addr);
        @(negedge clk1);
        monitor();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        halt       = 1'b0;
        flush      = 1'b0;
        flush_pc   = 32'd0;
        out_ready  = 1'b0;
        manual_ack = 1'b0;
        auto_ack   = 1'b1;
        rand_lat   = 1'b0;
        cur_lat    = 1;
        step();
        step();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL rst_mem: got req=%b addr=%h expected 0/0", mem_req, mem_addr);
        end
        checks++;
        if (occupancy !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_queue: got occ=%0d valid=%b expected 0/0", occupancy, out_valid);
        end
        checks++;
        if (out_ir !== 32'd0 || out_npc !== 32'd0) begin
            errors++;
            $display("FAIL rst_out: got ir=%h npc=%h expected 0/0", out_ir, out_npc);
        end
        // Reset during an outstanding request; a late ack must be ignored.
        auto_ack = 1'b0;
        n = 0;
        while (mem_req !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_timeout: got req=%b expected 1", mem_req);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        manual_ack = 1'b1;
        step();
        manual_ack = 1'b0;
        checks++;
        if (occupancy !== '0) begin
            errors++;
            $display("FAIL rst_late_ack: got occ=%0d expected 0", occupancy);
        end
        auto_ack = 1'b1;
        wait_cnt = 0;
        repeat (6) step();
    endtask

    task automatic test_in_order();
        do_reset();
        out_ready = 1'b1;
        repeat (20) step();
        checks++;
        if (pop_ir.size() < 3) begin
            errors++;
            $display("FAIL in_order_count: got %0d pops expected >= 3", pop_ir.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (pop_ir[i] !== 32'(100 + i) || pop_npc[i] !== 32'(i + 1)) begin
                    errors++;
                    $display("FAIL in_order_%0d: got (%0d,%0d) expected (%0d,%0d)",
                             i, pop_ir[i], pop_npc[i], 100 + i, i + 1);
                end
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        repeat (30) step();
        checks++;
        if (occupancy !== OW'(DEPTH) || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL full_stall: got occ=%0d req=%b expected %0d/0", occupancy, mem_req, DEPTH);
        end
        checks++;
        if (req_log.size() != DEPTH) begin
            errors++;
            $display("FAIL full_req_count: got %0d expected %0d", req_log.size(), DEPTH);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (20) step();
        checks++;
        if (req_log.size() != DEPTH + 1) begin
            errors++;
            $display("FAIL full_refill_count: got %0d expected %0d", req_log.size(), DEPTH + 1);
        end else begin
            checks++;
            if (req_log[DEPTH] !== AW'(4)) begin
                errors++;
                $display("FAIL full_refill_addr: got %h expected 4", req_log[DEPTH]);
            end
        end
        checks++;
        if (occupancy !== OW'(DEPTH)) begin
            errors++;
            $display("FAIL full_refill_occ: got %0d expected %0d", occupancy, DEPTH);
        end
    endtask

    task automatic test_flush_wait();
        int n;
        do_reset();
        auto_ack = 1'b0;
        n = 0;
        while (mem_req !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL flush_wait_timeout: got req=%b expected 1", mem_req);
        end
        flush    = 1'b1;
        flush_pc = 32'h20;
        step();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (mem_req !== 1'b1) begin
                errors++;
                $display("FAIL drain_hold_%0d: got req=%b expected 1", i, mem_req);
            end
            step();
        end
        manual_ack = 1'b1;
        step();
        manual_ack = 1'b0;
        auto_ack   = 1'b1;
        out_ready  = 1'b1;
        repeat (20) step();
        checks++;
        if (req_log.size() < 2 || req_log[1] !== AW'(32'h20)) begin
            errors++;
            $display("FAIL flush_wait_addr: got %0d requests expected second at 0x20", req_log.size());
        end
        checks++;
        if (pop_npc.size() < 1 || pop_npc[0] !== 32'h21 || pop_ir[0] !== 32'h20 + 32'd100) begin
            errors++;
            $display("FAIL flush_wait_pop: got %0d pops expected first npc=0x21 ir=0x84", pop_npc.size());
        end
    endtask

    task automatic test_flush_ack();
        int n;
        do_reset();
        n = 0;
        while (occupancy !== OW'(2) && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (occupancy !== OW'(2)) begin
            errors++;
            $display("FAIL flush_ack_fill: got occ=%0d expected 2", occupancy);
        end
        auto_ack = 1'b0;
        n = 0;
        while (mem_req !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL flush_ack_timeout: got req=%b expected 1", mem_req);
        end
        manual_ack = 1'b1;
        flush      = 1'b1;
        flush_pc   = 32'h40;
        step();
        manual_ack = 1'b0;
        flush      = 1'b0;
        checks++;
        if (occupancy !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_ack_empty: got occ=%0d valid=%b expected 0/0", occupancy, out_valid);
        end
        auto_ack = 1'b1;
        repeat (10) step();
        checks++;
        if (req_log.size() < 4 || req_log[3] !== AW'(32'h40)) begin
            errors++;
            $display("FAIL flush_ack_addr: got %0d requests expected fourth at 0x40", req_log.size());
        end
    endtask

    task automatic test_halt();
        int n;
        do_reset();
        halt      = 1'b1;
        out_ready = 1'b1;
        repeat (10) step();
        checks++;
        if (req_log.size() != 0) begin
            errors++;
            $display("FAIL halt_block: got %0d requests expected 0", req_log.size());
        end
        halt = 1'b0;
        n = 0;
        while (mem_req !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        halt = 1'b1;
        repeat (8) step();
        checks++;
        if (req_log.size() != 1 || pop_npc.size() != 1) begin
            errors++;
            $display("FAIL halt_outstanding: got %0d requests %0d pops expected 1/1",
                     req_log.size(), pop_npc.size());
        end
        halt = 1'b0;
    endtask

    task automatic test_hlt_detect();
        do_reset();
        hlt_word_en = 1'b1;
        out_ready   = 1'b1;
        repeat (40) step();
`ifdef PFQ_HLT_DETECT_EN
        checks++;
        if (req_log.size() != 6 || req_log[req_log.size()-1] !== AW'(5)) begin
            errors++;
            $display("FAIL hlt_stop: got %0d requests expected 6 ending at 5", req_log.size());
        end
        flush    = 1'b1;
        flush_pc = 32'h10;
        step();
        flush = 1'b0;
        repeat (10) step();
        checks++;
        if (req_log.size() < 7 || req_log[6] !== AW'(32'h10)) begin
            errors++;
            $display("FAIL hlt_resume: got %0d requests expected seventh at 0x10", req_log.size());
        end
`else
        checks++;
        if (req_log.size() < 7 || req_log[6] !== AW'(6)) begin
            errors++;
            $display("FAIL hlt_ignored: got %0d requests expected seventh at 6", req_log.size());
        end
`endif
        hlt_word_en = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            halt      = ($urandom_range(0, 99) < 20);
            flush     = ($urandom_range(0, 99) < 4);
            flush_pc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 1023));
            out_ready = ($urandom_range(0, 99) < 60);
            rst       = ($urandom_range(0, 499) == 0);
            step();
        end
        rst   = 1'b0;
        halt  = 1'b0;
        flush = 1'b0;
        checks++;
        if (pop_npc.size() < 100) begin
            errors++;
            $display("FAIL random_progress: got %0d pops expected >= 100", pop_npc.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        halt        = 1'b0;
        flush       = 1'b0;
        flush_pc    = 32'd0;
        out_ready   = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'd0;
        auto_ack    = 1'b1;
        manual_ack  = 1'b0;
        rand_lat    = 1'b0;
        cur_lat     = 1;
        hlt_word_en = 1'b0;
        p_req       = 1'b0;
        p_ack       = 1'b0;
        p_halt      = 1'b0;
        p_flush     = 1'b0;
        p_rst       = 1'b1;
        p_hlt       = 1'b0;
        p_count     = 0;
        p_addr      = '0;
        model_reset();
        @(posedge clk1);
        #1;

        test_reset();
        test_in_order();
        test_full();
        test_flush_wait();
        test_flush_ack();
        test_halt();
        test_hlt_detect();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
